// File: rtl/router_pkg.sv
// Shared router constants, the address type and a ceiling-log2 helper.
// Latency: n/a; backpressure: n/a.
package router_pkg;

    localparam int ROUTER_PORTS   = 3;
    localparam int ROUTER_ADDR_W  = 2;
    localparam int ROUTER_TIMEOUT = 30;

    typedef logic [ROUTER_ADDR_W-1:0] addr_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sync_port_timer.sv
// Per-port read-timeout counter: soft_rst pulses after TIMEOUT unread-valid cycles.
// Latency: pulse on the edge ending the TIMEOUT-th such cycle; backpressure: any read clears the count.
module sync_port_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic              re,
    input  logic              timeout_en,
    output logic              soft_rst,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
            drop_cnt <= '0;
        end else if (!vld || re || !timeout_en) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (cnt == LAST) begin
            cnt      <= '0;
            soft_rst <= 1'b1;
            // Saturate rather than wrap so a stuck port stays visibly at max.
            if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
        end else begin
            cnt      <= cnt + CNT_W'(1);
            soft_rst <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_mp.sv
// Multi-port router synchronizer: header address latch, write-enable/full decode, per-port timeouts.
// Latency: address takes effect 1 cycle after detect_addr; backpressure: fifo_full stalls the FSM, forced on bad address.
module router_sync_mp
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_PORTS,
    parameter int ADDR_W    = ROUTER_ADDR_W,
    parameter int TIMEOUT   = ROUTER_TIMEOUT,
    parameter int CNT_W     = clog2(ROUTER_TIMEOUT + 1),
    parameter int DROP_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        detect_addr,
    input  logic [ADDR_W-1:0]           din,
    input  logic                        write_enb_reg,
    input  logic [NUM_PORTS-1:0]        re,
    input  logic [NUM_PORTS-1:0]        empty,
    input  logic [NUM_PORTS-1:0]        full,
    input  logic                        timeout_en,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic [NUM_PORTS-1:0]        soft_rst,
    output logic [NUM_PORTS-1:0]        we,
    output logic                        fifo_full,
    output logic                        addr_err,
    output logic [ADDR_W-1:0]           cur_addr,
    output logic [NUM_PORTS*DROP_W-1:0] drop_cnt
);

    logic [NUM_PORTS-1:0] port_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr <= '0;
            addr_err <= 1'b0;
        end else if (detect_addr) begin
            cur_addr <= din;
            addr_err <= (32'(din) >= NUM_PORTS);
        end
    end

    // An out-of-range address shifts the select bit off the end, leaving it all-zero.
    always_comb begin
        port_sel  = NUM_PORTS'(1) << cur_addr;
        we        = '0;
        fifo_full = addr_err | (|(full & port_sel));
        if (write_enb_reg && !addr_err) we = port_sel;
    end

    assign vld_out = ~empty;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sync_port_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W),
            .DROP_W  (DROP_W)
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld_out[i]),
            .re         (re[i]),
            .timeout_en (timeout_en),
            .soft_rst   (soft_rst[i]),
            .drop_cnt   (drop_cnt[i*DROP_W +: DROP_W])
        );
    end

endmodule

// File: tb/tb_router_sync_mp.sv
// Bench for router_sync_mp: directed scenarios plus randomized traffic against a run-length model.
// Latency: n/a; backpressure: n/a.
module tb_router_sync_mp;
    import router_pkg::*;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 30;
    localparam int CW = 5;
    localparam int DW = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            detect_addr;
    addr_t           din;
    logic            write_enb_reg;
    logic [NP-1:0]   re, empty, full;
    logic            timeout_en;
    logic [NP-1:0]   vld_out, soft_rst, we;
    logic            fifo_full, addr_err;
    logic [AW-1:0]   cur_addr;
    logic [NP*DW-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state: length of the current unread-valid run, last pulse, event totals.
    int            m_run [NP];
    logic [NP-1:0] m_pulse;
    int            m_drop [NP];
    int            m_addr;
    bit            m_err;

    router_sync_mp #(
        .NUM_PORTS (NP), .ADDR_W (AW), .TIMEOUT (TO), .CNT_W (CW), .DROP_W (DW)
    ) dut (
        .clk (clk), .rst (rst), .detect_addr (detect_addr), .din (din),
        .write_enb_reg (write_enb_reg), .re (re), .empty (empty), .full (full),
        .timeout_en (timeout_en), .vld_out (vld_out), .soft_rst (soft_rst), .we (we),
        .fifo_full (fifo_full), .addr_err (addr_err), .cur_addr (cur_addr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NP-1:0] exp_we();
        if (write_enb_reg && !m_err) return NP'(1) << m_addr;
        return '0;
    endfunction

    function automatic logic exp_full();
        if (m_err) return 1'b1;
        return full[m_addr];
    endfunction

    function automatic logic [NP*DW-1:0] exp_drop();
        logic [NP*DW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = DW'(m_drop[i]);
        return v;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then settle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_addr = 0; m_err = 0; m_pulse = '0;
            for (int i = 0; i < NP; i++) begin m_run[i] = 0; m_drop[i] = 0; end
        end else begin
            if (detect_addr) begin m_addr = int'(din); m_err = (int'(din) >= NP); end
            for (int i = 0; i < NP; i++) begin
                if (empty[i] || re[i] || !timeout_en) begin
                    m_run[i] = 0; m_pulse[i] = 1'b0;
                end else begin
                    m_run[i]++;
                    m_pulse[i] = (m_run[i] == TO);
                    if (m_run[i] == TO) begin
                        m_run[i] = 0;
                        if (m_drop[i] < DMAX) m_drop[i]++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        detect_addr = 0; din = '0; write_enb_reg = 0; re = '0; empty = '1;
        full = '0; timeout_en = 1; rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        detect_addr = 0; write_enb_reg = 1; re = '0; empty = '1; full = 3'b001;
        timeout_en = 1; rst = 1;
        step();
        checks++; if (cur_addr !== '0) begin failures++; $display("FAIL reset_cur_addr got=%0d exp=0", cur_addr); end
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        checks++; if (soft_rst !== '0) begin failures++; $display("FAIL reset_soft_rst got=%b exp=000", soft_rst); end
        checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt); end
        rst = 0; write_enb_reg = 0; #1;
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL reset_fifo_full got=%b exp=1", fifo_full); end
        write_enb_reg = 1; #1;
        checks++; if (we !== 3'b001) begin failures++; $display("FAIL reset_we got=%b exp=001", we); end
        write_enb_reg = 0;
    endtask

    task automatic test_addr();
        do_reset();
        detect_addr = 1; din = 2'd2;
        step();
        detect_addr = 0; write_enb_reg = 1; #1;
        checks++; if (cur_addr !== 2'd2) begin failures++; $display("FAIL addr_cur got=%0d exp=2", cur_addr); end
        checks++; if (we !== 3'b100) begin failures++; $display("FAIL addr_we2 got=%b exp=100", we); end
        for (int k = 0; k < 4; k++) begin
            full = NP'($urandom);
            #1;
            checks++; if (fifo_full !== full[2]) begin failures++; $display("FAIL addr_full2 got=%b exp=%b", fifo_full, full[2]); end
        end
        detect_addr = 1; din = 2'd3; full = '0;
        step();
        detect_addr = 0; #1;
        checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err3 got=%b exp=1", addr_err); end
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL addr_full3 got=%b exp=1", fifo_full); end
        checks++; if (we !== 3'b000) begin failures++; $display("FAIL addr_we3 got=%b exp=000", we); end
        detect_addr = 1; din = 2'd1;
        step();
        detect_addr = 0; #1;
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL addr_err1 got=%b exp=0", addr_err); end
        checks++; if (we !== 3'b010) begin failures++; $display("FAIL addr_we1 got=%b exp=010", we); end
        write_enb_reg = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        empty = 3'b110;
        for (int k = 1; k <= 61; k++) begin
            step();
            checks++;
            if (soft_rst[0] !== ((k == 30) || (k == 60))) begin
                failures++; $display("FAIL timeout_pulse edge=%0d got=%b", k, soft_rst[0]);
            end
            checks++; if (soft_rst !== m_pulse) begin failures++; $display("FAIL timeout_model edge=%0d got=%b exp=%b", k, soft_rst, m_pulse); end
        end
        checks++; if (vld_out !== 3'b001) begin failures++; $display("FAIL vld_out got=%b exp=001", vld_out); end
        checks++; if (drop_cnt[DW-1:0] !== 8'd2) begin failures++; $display("FAIL timeout_drop got=%0d exp=2", drop_cnt[DW-1:0]); end
    endtask

    task automatic test_re_cancel();
        do_reset();
        empty = 3'b110;
        for (int k = 1; k <= 61; k++) begin
            re = (k == 30) ? 3'b001 : 3'b000;
            step();
            checks++;
            if (soft_rst[0] !== (k == 60)) begin
                failures++; $display("FAIL re_cancel edge=%0d got=%b", k, soft_rst[0]);
            end
        end
        re = '0;
        checks++; if (drop_cnt[DW-1:0] !== 8'd1) begin failures++; $display("FAIL re_cancel_drop got=%0d exp=1", drop_cnt[DW-1:0]); end
    endtask

    task automatic test_disable_and_reset();
        do_reset();
        empty = 3'b110; timeout_en = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++; if (soft_rst !== '0) begin failures++; $display("FAIL disabled edge=%0d got=%b exp=000", k, soft_rst); end
        end
        timeout_en = 1;
        for (int k = 1; k <= 45; k++) begin
            step();
            checks++; if (soft_rst !== m_pulse) begin failures++; $display("FAIL enabled edge=%0d got=%b exp=%b", k, soft_rst, m_pulse); end
        end
        checks++; if (drop_cnt[DW-1:0] !== 8'd1) begin failures++; $display("FAIL pre_rst_drop got=%0d exp=1", drop_cnt[DW-1:0]); end
        rst = 1;
        step();
        rst = 0;
        checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL mid_rst_drop got=%h exp=0", drop_cnt); end
        for (int k = 1; k <= 31; k++) begin
            step();
            checks++; if (soft_rst[0] !== (k == 30)) begin failures++; $display("FAIL post_rst edge=%0d got=%b", k, soft_rst[0]); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        empty = 3'b101;
        for (int k = 1; k <= 300 * TO; k++) begin
            step();
            checks++; if (soft_rst !== m_pulse) begin failures++; $display("FAIL sat_pulse edge=%0d got=%b exp=%b", k, soft_rst, m_pulse); end
        end
        checks++; if (drop_cnt[DW +: DW] !== 8'd255) begin failures++; $display("FAIL sat_drop1 got=%0d exp=255", drop_cnt[DW +: DW]); end
        checks++; if (drop_cnt[0 +: DW] !== 8'd0) begin failures++; $display("FAIL sat_drop0 got=%0d exp=0", drop_cnt[0 +: DW]); end
        checks++; if (drop_cnt[2*DW +: DW] !== 8'd0) begin failures++; $display("FAIL sat_drop2 got=%0d exp=0", drop_cnt[2*DW +: DW]); end
    endtask

    task automatic test_random();
        do_reset();
        empty = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 700 == 0);
            detect_addr = ($urandom % 4 == 0);
            din = AW'($urandom);
            write_enb_reg = $urandom % 2;
            full = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom % 16 == 0) empty[i] = ~empty[i] | ($urandom % 2 == 0);
                re[i] = ($urandom % 64 == 0);
            end
            timeout_en = ($urandom % 100 != 0);
            step();
            checks++;
            if (we !== exp_we() || fifo_full !== exp_full()) begin
                failures++; $display("FAIL rnd_decode cyc=%0d we=%b/%b full=%b/%b", k, we, exp_we(), fifo_full, exp_full());
            end
            checks++;
            if (cur_addr !== AW'(m_addr) || addr_err !== m_err) begin
                failures++; $display("FAIL rnd_addr cyc=%0d addr=%0d/%0d err=%b/%b", k, cur_addr, m_addr, addr_err, m_err);
            end
            checks++;
            if (soft_rst !== m_pulse || vld_out !== ~empty) begin
                failures++; $display("FAIL rnd_port cyc=%0d soft=%b/%b vld=%b/%b", k, soft_rst, m_pulse, vld_out, ~empty);
            end
            checks++;
            if (drop_cnt !== exp_drop()) begin
                failures++; $display("FAIL rnd_drop cyc=%0d got=%h exp=%h", k, drop_cnt, exp_drop());
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_addr();
        test_timeout();
        test_re_cancel();
        test_disable_and_reset();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
